// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer: opcode constants, the controller
// FSM state encoding, architectural flag bit positions and a legality helper.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int DW = 8;  // datapath / register width

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd11;
  localparam logic [3:0] OP_LOADI = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPER = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Bit positions inside the 4-bit flag vector {C, Z, N, V}.
  localparam int FL_C = 3;
  localparam int FL_Z = 2;
  localparam int FL_N = 1;
  localparam int FL_V = 0;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LOADI: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  // Opcode presented to the ALU: LOADI and illegal ops never reach it.
  function automatic logic [3:0] alu_op_of(input logic [3:0] op);
    return (is_legal(op) && (op != OP_LOADI)) ? op : OP_ADD;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NREG x 8-bit register file with two asynchronous read ports and one
// synchronous write port. Synchronous active-high reset clears every entry.
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   we_i       write enable
//   waddr_i    write index
//   wdata_i    write data
//   raddr_a_i  read port A index  -> rdata_a_o
//   raddr_b_i  read port B index  -> rdata_b_o
// -----------------------------------------------------------------------------
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter  int NREG = 4,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           we_i,
  input  logic [RAW-1:0] waddr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic [RAW-1:0] raddr_a_i,
  output logic [DW-1:0]  rdata_a_o,
  input  logic [RAW-1:0] raddr_b_i,
  output logic [DW-1:0]  rdata_b_o
);

  logic [DW-1:0] regs_q [NREG];

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: resetting an array forces it into flops rather than a RAM macro;
      // acceptable here because the file is tiny and zero-after-reset is
      // architecturally visible.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Accepts one instruction at a time over cmd_valid/cmd_ready, reads operands
// from the internal register file, drives registered operands/opcode to an
// external combinational ALU, captures result and flags one full cycle later,
// writes back, and emits a one-cycle response.
//   clk, rst                     clock / synchronous active-high reset
//   cmd_valid, cmd_ready         command handshake
//   cmd_op, cmd_dst/a/b, cmd_imm command fields
//   alu_in1, alu_in2, alu_op     registered ALU inputs
//   alu_out, alu_flags           ALU result and {C,Z,N,V}
//   rsp_valid                    one-cycle response strobe
//   rsp_data, rsp_flags, rsp_err held response payload
// Sequence: IDLE -> OPER (ALU settles) -> CAPT (writeback) -> RESP -> IDLE.
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int NREG = 4,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [3:0]     cmd_op,
  input  logic [RAW-1:0] cmd_dst,
  input  logic [RAW-1:0] cmd_a,
  input  logic [RAW-1:0] cmd_b,
  input  logic [7:0]     cmd_imm,
  output logic [7:0]     alu_in1,
  output logic [7:0]     alu_in2,
  output logic [3:0]     alu_op,
  input  logic [7:0]     alu_out,
  input  logic [3:0]     alu_flags,
  output logic           rsp_valid,
  output logic [7:0]     rsp_data,
  output logic [3:0]     rsp_flags,
  output logic           rsp_err
);

  state_e         state_q;
  logic [3:0]     op_q;
  logic [RAW-1:0] dst_q;
  logic [7:0]     imm_q;
  logic [7:0]     alu_in1_q, alu_in2_q;
  logic [3:0]     alu_op_q;
  logic [3:0]     flags_q, flags_d;
  logic           rsp_valid_q, rsp_err_q;
  logic [7:0]     rsp_data_q;
  logic [3:0]     rsp_flags_q;

  logic [7:0]     rd_a, rd_b;
  logic           wr_en;
  logic [7:0]     wr_data;
  logic           legal;

  assign legal   = is_legal(op_q);
  assign wr_en   = (state_q == ST_CAPT) && legal;
  assign wr_data = (op_q == OP_LOADI) ? imm_q : alu_out;

  alu_regfile #(.NREG(NREG)) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (wr_en),
    .waddr_i   (dst_q),
    .wdata_i   (wr_data),
    .raddr_a_i (cmd_a),
    .rdata_a_o (rd_a),
    .raddr_b_i (cmd_b),
    .rdata_b_o (rd_b)
  );

  // Architectural flags after the command in CAPT. Carry only survives ADD.
  always_comb begin
    // NOTE: default first so every path assigns flags_d and no latch is inferred.
    flags_d = flags_q;
    if (legal && (op_q != OP_LOADI)) begin
      flags_d[FL_Z] = alu_flags[FL_Z];
      flags_d[FL_N] = alu_flags[FL_N];
      flags_d[FL_V] = alu_flags[FL_V];
      flags_d[FL_C] = (op_q == OP_ADD) ? alu_flags[FL_C] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      imm_q       <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_op_q    <= '0;
      flags_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Operands are sampled here, so an aliased dst cannot disturb them.
            op_q      <= cmd_op;
            dst_q     <= cmd_dst;
            imm_q     <= cmd_imm;
            alu_in1_q <= rd_a;
            alu_in2_q <= rd_b;
            alu_op_q  <= alu_op_of(cmd_op);
            state_q   <= ST_OPER;
          end
        end
        ST_OPER: state_q <= ST_CAPT;
        ST_CAPT: begin
          flags_q     <= flags_d;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= legal ? wr_data : 8'h00;
          rsp_flags_q <= flags_d;
          rsp_err_q   <= ~legal;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller that sequences the 8-bit ALU datapath. It accepts one instruction at a time over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU operand and opcode inputs, captures the result and flags, writes back, and emits a one-cycle response. It sits between the control unit and the combinational ALU, which is instantiated alongside it at the top level.

## Interface
- NREG, 4, number of 8-bit registers (power of 2); index width RAW = log2(NREG)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 11 NOT, 15 LOADI; all others illegal
- cmd_dst / cmd_a / cmd_b  in  RAW  destination / operand-A / operand-B register index
- cmd_imm  in  8  immediate for LOADI
- alu_in1 / alu_in2  out  8  registered ALU operands
- alu_op  out  4  registered ALU opcode
- alu_out  in  8  ALU result (combinational)
- alu_flags  in  4  ALU flags {carry, zero, negative, overflow}
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  8  value written to dst (0 on error)
- rsp_flags  out  4  architectural flags after the command
- rsp_err  out  1  illegal opcode

## Operation
- **FSM states:** IDLE → OPER → CAPT → RESP → IDLE. There are no other transitions except reset.
- **IDLE:**
  - cmd_ready = 1 (0 while rst is high).
  - On cmd_valid & cmd_ready, latch op, dst and imm.
  - Load alu_in1 = R[cmd_a] and alu_in2 = R[cmd_b].
  - Load alu_op = cmd_op, with illegal ops and LOADI mapped to 0.
- **OPER:** ALU settles. No state is updated.
- **CAPT** (per opcode):
  - Legal ALU op: write R[dst] ← alu_out and update the flags register.
    - flags[2:0] ← alu_flags[2:0].
    - flags[3] ← alu_flags[3] for ADD, 0 otherwise.
  - LOADI: R[dst] ← imm; flags unchanged.
  - Illegal op: no register write; flags unchanged; set the error bit.
- **RESP:**
  - rsp_valid = 1 for exactly one cycle.
  - rsp_data, rsp_flags and rsp_err are registered and held until the next RESP.
  - No backpressure on the response.
- **Operand aliasing:** dst, a and b may alias. Operands are sampled in IDLE, so writeback never corrupts the current command.
- **Read-after-write:** writeback completes before the next IDLE, so a following command always sees the new value.
- **Reset:**
  - State → IDLE.
  - All registers, the flags register, alu_in1, alu_in2, alu_op and rsp_* → 0; rsp_valid = 0.
- **Reset mid-operation:** the command is aborted, with no writeback and no response.

## Timing
- Handshake sampled at rising edge N.
- alu_in1/in2/op are valid from edge N+1.
- Register write occurs at edge N+3.
- rsp_valid is high during cycle N+3..N+4.
- cmd_ready returns at N+4.
- Throughput: one command per 4 cycles. Back-to-back commands with cmd_valid held high are accepted at N and N+4.
- cmd_* is ignored outside IDLE. The commander must hold it stable only until the handshake.
- The ALU path is a full cycle, from registered operands to CAPT capture. alu_* is never sampled combinationally in the same cycle it changes.

## Structure
- **Package alu_seq_pkg:**
  - Opcode constants: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LOADI.
  - FSM state encoding (2 bits).
  - Flag bit positions: FL_C = 3, FL_Z = 2, FL_N = 1, FL_V = 0.
  - Function is_legal(op).
- **Sub-module alu_regfile:**
  - NREG × 8 registers, two asynchronous read ports, one synchronous write port.
  - Synchronous reset to 0.
- The ALU itself stays outside the controller.

## Test plan
- **LOADI and overflow:** LOADI r0 = 0x7F, LOADI r1 = 0x01, then ADD r2 = r0 + r1 → rsp_data 0x80, rsp_flags 4'b0011, rsp_err 0, rsp_valid exactly at N+3.
- **Add with carry:** LOADI r0 = 0xFF, r1 = 0x01, ADD r0 = r0 + r1 (dst aliases a) → rsp_data 0x00, rsp_flags 4'b1100, r0 reads 0x00.
- **Zero result, carry cleared:** SUB r3 = r2 − r2 with r2 = 0x05 → rsp_data 0x00, flags[2] = 1, flags[3] = 0. NOT r1 of r0 = 0x0F → rsp_data 0xF0, flags[2:1] = 2'b01.
- **Illegal opcode:** op 5 with dst = r1 holding 0x3C → rsp_err 1, rsp_data 0x00, r1 still 0x3C, rsp_flags unchanged.
- **Back-to-back:** cmd_valid held high for two commands (ADD r2 = r0 + r1, then ADD r3 = r2 + r2) → second accepted exactly 4 cycles after the first and uses the new r2. cmd_ready is low for 3 cycles between them.
- **Reset mid-operation:** rst asserted for one cycle during CAPT → no rsp_valid, all registers read 0 afterwards, cmd_ready = 1 the cycle after rst deasserts.
